// File: rtl/piano_pkg.sv
// piano_pkg: shared note indices, player state encoding and priority helper
package piano_pkg;
  localparam int NUM_NOTES = 8;
  localparam int NOTE_C4 = 0;
  localparam int NOTE_D4 = 1;
  localparam int NOTE_E4 = 2;
  localparam int NOTE_F4 = 3;
  localparam int NOTE_G4 = 4;
  localparam int NOTE_A4 = 5;
  localparam int NOTE_B4 = 6;
  localparam int NOTE_C5 = 7;
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, RELEASE} player_state_t;
  function automatic logic [2:0] lowest_set(input logic [NUM_NOTES-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: 2-FF synchronizer plus tick-sampled run counter for one key
module key_debouncer #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic key,
  input  logic tick,
  output logic debounced
);
  localparam int RW = $clog2(STABLE_SAMPLES + 1);
  logic [1:0] sync;
  logic [RW-1:0] run;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync <= '0;
      run <= '0;
      debounced <= 1'b0;
    end else begin
      sync <= {sync[0], key};
      if (tick) begin
        if (sync[1] == debounced) run <= '0;
        else if (run == RW'(STABLE_SAMPLES - 1)) begin
          run <= '0;
          debounced <= ~debounced;
        end else run <= run + 1'b1;
      end
    end
  end
endmodule

// File: rtl/note_player.sv
// note_player: debounced priority note selection with glitch-free speaker; RELEASE_TAIL_EN enables the release sustain
module note_player
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_TICK  = 100000,
  parameter int STABLE_SAMPLES = 4,
  parameter int RELEASE_CYCLES = 25000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_NOTES-1:0] KEYS,
  input  logic [NUM_NOTES-1:0] NOTE_CLKS,
  output logic                 SPEAKER,
  output logic [2:0]           ACTIVE_NOTE,
  output logic                 NOTE_VALID
);
  localparam int TW = DEBOUNCE_TICK > 1 ? $clog2(DEBOUNCE_TICK) : 1;
  logic [TW-1:0] tick_cnt;
  logic tick;
  logic [NUM_NOTES-1:0] keys_db;
  logic [2:0] sel, cur, cur_nxt;
  logic any, wave, rel_done;
  player_state_t state, state_nxt;
  assign tick = tick_cnt == TW'(DEBOUNCE_TICK - 1);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end
  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_key
    key_debouncer #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db (
      .CLK(CLK),
      .RESET(RESET),
      .key(KEYS[i]),
      .tick(tick),
      .debounced(keys_db[i])
    );
  end
  assign sel = lowest_set(keys_db);
  assign any = |keys_db;
  assign wave = NOTE_CLKS[cur];
`ifdef RELEASE_TAIL_EN
  localparam int RW = RELEASE_CYCLES > 1 ? $clog2(RELEASE_CYCLES) : 1;
  logic [RW-1:0] rel_cnt;
  assign rel_done = rel_cnt == RW'(RELEASE_CYCLES - 1);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rel_cnt <= '0;
    else if ((state == PLAY && !any) || (state == RELEASE && any && sel == cur)) rel_cnt <= '0;
    else if (state == RELEASE && !any && !rel_done) rel_cnt <= rel_cnt + 1'b1;
  end
`else
  assign rel_done = 1'b1;
`endif
  // a note change is only committed while the current wave is low
  always_comb begin
    state_nxt = state;
    cur_nxt = cur;
    case (state)
      IDLE: if (any) begin
        cur_nxt = sel;
        state_nxt = PLAY;
      end
      PLAY: if (!any) state_nxt = RELEASE;
        else if (sel != cur) state_nxt = DRAIN;
      DRAIN: if (!any) state_nxt = RELEASE;
        else if (!wave) begin
          cur_nxt = sel;
          state_nxt = PLAY;
        end
      RELEASE: if (any) state_nxt = sel == cur ? PLAY : DRAIN;
        else if (rel_done && !wave) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cur <= '0;
      SPEAKER <= 1'b0;
    end else begin
      state <= state_nxt;
      cur <= cur_nxt;
      SPEAKER <= state == IDLE ? 1'b0 : wave;
    end
  end
  assign ACTIVE_NOTE = cur;
  assign NOTE_VALID = state != IDLE;
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed self-checking bench for note_player
module tb_note_player;
  logic CLK = 1'b0;
  logic RESET;
  logic [7:0] KEYS;
  logic [7:0] note_clks;
  logic SPEAKER;
  logic [2:0] ACTIVE_NOTE;
  logic NOTE_VALID;
  logic auto_w;
  int wcnt = 0;
  int n_assert = 0;
  int n_fail = 0;
  note_player #(.DEBOUNCE_TICK(4), .STABLE_SAMPLES(2), .RELEASE_CYCLES(16)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .KEYS(KEYS),
    .NOTE_CLKS(note_clks),
    .SPEAKER(SPEAKER),
    .ACTIVE_NOTE(ACTIVE_NOTE),
    .NOTE_VALID(NOTE_VALID)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // waves: note i has a half period of i+2 cycles while auto_w is set
  task automatic step();
    @(negedge CLK);
    if (auto_w) begin
      wcnt++;
      for (int i = 0; i < 8; i++) note_clks[i] = ((wcnt / (i + 2)) % 2) == 1;
    end
  endtask
  task automatic wait_valid(input logic lvl, input int budget, output int n);
    n = 0;
    while (NOTE_VALID !== lvl && n < budget) begin
      step();
      n++;
    end
  endtask
  initial begin
    int n, errs;
    logic prev, seen;
    RESET = 1'b1;
    KEYS = 8'h00;
    note_clks = 8'h00;
    auto_w = 1'b1;
    repeat (3) step();
    chk("reset_speaker", 8'(SPEAKER), 8'h0);
    chk("reset_valid", 8'(NOTE_VALID), 8'h0);
    chk("reset_active", 8'(ACTIVE_NOTE), 8'h0);
    RESET = 1'b0;
    repeat (3) step();
    KEYS = 8'h10;
    seen = 1'b0;
    repeat (4) begin
      step();
      seen |= NOTE_VALID | SPEAKER;
    end
    KEYS = 8'h00;
    repeat (20) begin
      step();
      seen |= NOTE_VALID | SPEAKER;
    end
    chk("glitch_ignored", 8'(seen), 8'h0);
    KEYS = 8'h10;
    wait_valid(1'b1, 12, n);
    chk("hold_valid", 8'(NOTE_VALID), 8'h1);
    chk("hold_active", 8'(ACTIVE_NOTE), 8'h4);
    errs = 0;
    for (int k = 0; k < 24; k++) begin
      prev = note_clks[4];
      step();
      if (SPEAKER !== prev) errs++;
    end
    chk("speaker_follow_errs", 8'(errs), 8'h0);
    auto_w = 1'b0;
    note_clks = 8'h10;
    KEYS = 8'h12;
    repeat (14) step();
    chk("drain_active", 8'(ACTIVE_NOTE), 8'h4);
    chk("drain_valid", 8'(NOTE_VALID), 8'h1);
    chk("drain_speaker", 8'(SPEAKER), 8'h1);
    note_clks = 8'h00;
    step();
    chk("switch_active", 8'(ACTIVE_NOTE), 8'h1);
    chk("switch_speaker", 8'(SPEAKER), 8'h0);
    note_clks = 8'h02;
    step();
    chk("new_note_speaker", 8'(SPEAKER), 8'h1);
    KEYS = 8'h00;
    repeat (40) step();
    chk("release_high_valid", 8'(NOTE_VALID), 8'h1);
    chk("release_high_speaker", 8'(SPEAKER), 8'h1);
    chk("release_high_active", 8'(ACTIVE_NOTE), 8'h1);
    note_clks = 8'h00;
    step();
    chk("release_drop_valid", 8'(NOTE_VALID), 8'h0);
    chk("release_drop_speaker", 8'(SPEAKER), 8'h0);
    auto_w = 1'b1;
    KEYS = 8'h44;
    wait_valid(1'b1, 12, n);
    chk("chord_valid", 8'(NOTE_VALID), 8'h1);
    chk("chord_active", 8'(ACTIVE_NOTE), 8'h2);
    auto_w = 1'b0;
    note_clks = 8'h00;
    KEYS = 8'h00;
    wait_valid(1'b0, 60, n);
    chk("release_time_valid", 8'(NOTE_VALID), 8'h0);
`ifdef RELEASE_TAIL_EN
    chk("release_time_tail", 8'(n >= 23 && n <= 28), 8'h1);
`else
    chk("release_time_notail", 8'(n >= 7 && n <= 13), 8'h1);
`endif
    auto_w = 1'b1;
    KEYS = 8'h10;
    wait_valid(1'b1, 12, n);
    chk("replay_active", 8'(ACTIVE_NOTE), 8'h4);
    auto_w = 1'b0;
    note_clks = 8'h10;
    KEYS = 8'h00;
    repeat (20) step();
    chk("pre_reset_valid", 8'(NOTE_VALID), 8'h1);
    chk("pre_reset_speaker", 8'(SPEAKER), 8'h1);
    #1 RESET = 1'b1;
    KEYS = 8'h10;
    #1;
    chk("async_reset_speaker", 8'(SPEAKER), 8'h0);
    chk("async_reset_valid", 8'(NOTE_VALID), 8'h0);
    chk("async_reset_active", 8'(ACTIVE_NOTE), 8'h0);
    repeat (3) step();
    RESET = 1'b0;
    repeat (8) step();
    chk("post_reset_debounce_wait", 8'(NOTE_VALID), 8'h0);
    step();
    chk("post_reset_valid", 8'(NOTE_VALID), 8'h1);
    chk("post_reset_active", 8'(ACTIVE_NOTE), 8'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
